jtag_ahb_master_ctrl: RTL and testbench

// - Executes AHB-Lite master transfers on the system bus, driven by 41-bit command words from the JTAG AHB data register.
// - Command words reach the system clock domain through the async command FIFO. This block pops them, decodes them and runs single or

---
 rtl/jtag_types_pkg.sv | 37 +++
 rtl/jtag_ahb_addr_gen.sv | 54 +++++
 rtl/jtag_ahb_master_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_jtag_ahb_master_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_types_pkg.sv
// Shared types and constants for the JTAG-to-AHB master controller.
//   ahb_cmd_t        : 41-bit command word as delivered by the command FIFO
//   ahb_ctrl_state_t : controller FSM states
//   HTRANS_*         : AHB transfer type encodings used by the master
//   ERR_*            : bit positions inside err_status
//   size_step()      : byte increment for an incrementing burst of a given size
package jtag_types_pkg;

  typedef struct packed {
    logic        is_addr;   // 1: ADDR word, 0: DATA word
    logic [3:0]  beats_m1;  // beat count minus one
    logic        incr;      // incrementing address between beats
    logic        write;     // 1: write burst, 0: read burst
    logic [1:0]  size;      // log2 of transfer bytes
    logic [31:0] addr;      // start address (ADDR) or write data (DATA)
  } ahb_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_DATA    = 3'd2,
    ST_WAIT_WD = 3'd3,
    ST_DRAIN   = 3'd4
  } ahb_ctrl_state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam int ERR_HRESP   = 0;
  localparam int ERR_PROTO   = 1;
  localparam int ERR_TIMEOUT = 2;

  function automatic logic [31:0] size_step(input logic [1:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/jtag_ahb_addr_gen.sv
// Burst address / beat bookkeeping for the JTAG AHB master.
// Holds the current beat address, transfer size, increment mode and the
// number of beats still to run after the current one.
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   load            capture a new command (addr/size/incr/beats_m1)
//   load_*          fields of the new command
//   step            current beat finished: count down, advance address if incr
//   addr            current beat address
//   size            current transfer size
//   beats_left      beats remaining after the current one
//   last_beat       current beat is the final one of the burst
module jtag_ahb_addr_gen
  import jtag_types_pkg::*;
#(
  parameter int unsigned BEAT_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic [31:0]       load_addr,
  input  logic [1:0]        load_size,
  input  logic              load_incr,
  input  logic [BEAT_W-1:0] load_beats_m1,
  input  logic              step,
  output logic [31:0]       addr,
  output logic [1:0]        size,
  output logic [BEAT_W-1:0] beats_left,
  output logic              last_beat
);

  logic incr_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr       <= '0;
      size       <= '0;
      incr_q     <= 1'b0;
      beats_left <= '0;
    end else if (load) begin
      addr       <= load_addr;
      size       <= load_size;
      incr_q     <= load_incr;
      beats_left <= load_beats_m1;
    end else if (step) begin
      beats_left <= beats_left - 1'b1;
      // 32-bit add wraps naturally past 0xFFFFFFFF
      if (incr_q) addr <= addr + size_step(size);
    end
  end

  assign last_beat = (beats_left == '0);

endmodule

// File: rtl/jtag_ahb_master_ctrl.sv
// AHB-Lite master driven by JTAG command words.
// Pops 41-bit commands from the (FWFT) command FIFO, runs single or
// incrementing bursts with one NONSEQ per beat, and pushes read data into
// the readback FIFO. Protocol, bus-error and timeout events are collected in
// the sticky err_status register.
// Optional feature: define JTAG_AHB_TIMEOUT_EN to enable the HREADY-low
// watchdog (TIMEOUT_CYCLES); otherwise DATA waits forever and err[2] is 0.
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   fifo_rdata/empty/rinc command FIFO head word, empty flag, pop pulse
//   rb_wdata/winc/full    readback FIFO data, push pulse, full flag
//   HADDR..HWDATA         AHB master address/control/write-data outputs
//   HRDATA/HREADY/HRESP   AHB slave response inputs
//   err_clr               clear err_status (set wins in the same cycle)
//   busy                  controller not in IDLE
//   err_status            sticky [0] HRESP, [1] protocol, [2] timeout
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for an ADDR word
// ST_WAIT_WD | write burst, waiting for the next DATA word
// ST_ADDR    | address phase (NONSEQ); reads hold here while rb_full
// ST_DATA    | data phase, waiting for HREADY
// ST_DRAIN   | bus error on a write burst, discarding its remaining DATA words
module jtag_ahb_master_ctrl
  import jtag_types_pkg::*;
#(
  parameter int unsigned MAX_BEATS      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [40:0] fifo_rdata,
  input  logic        fifo_empty,
  output logic        fifo_rinc,
  output logic [31:0] rb_wdata,
  output logic        rb_winc,
  input  logic        rb_full,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic        err_clr,
  output logic        busy,
  output logic [2:0]  err_status
);

  localparam int unsigned BEAT_W = $clog2(MAX_BEATS);

  ahb_cmd_t        cmd;
  ahb_ctrl_state_t state, state_nxt, decode_nxt;
  logic            cmd_valid, cmd_ok;
  logic            write_q;
  logic [31:0]     wdata_q;
  logic [2:0]      err_q, err_set;
  logic            load, step, wdata_load, rb_push, timeout;
  logic [1:0]      htrans;
  logic [31:0]     cur_addr;
  logic [1:0]      cur_size;
  logic [BEAT_W-1:0] beats_left;
  logic            last_beat;

  assign cmd       = fifo_rdata;
  assign cmd_valid = !fifo_empty;
  assign cmd_ok    = cmd.is_addr && (cmd.size != 2'b11);

  // Where a freshly popped word leads when treated as the start of a command.
  always_comb begin
    decode_nxt = ST_IDLE;
    if (cmd_ok) decode_nxt = cmd.write ? ST_WAIT_WD : ST_ADDR;
  end

  jtag_ahb_addr_gen #(.BEAT_W(BEAT_W)) u_addr_gen (
    .CLK           (CLK),
    .RST           (RST),
    .load          (load),
    .load_addr     (cmd.addr),
    .load_size     (cmd.size),
    .load_incr     (cmd.incr),
    .load_beats_m1 (BEAT_W'(cmd.beats_m1)),
    .step          (step),
    .addr          (cur_addr),
    .size          (cur_size),
    .beats_left    (beats_left),
    .last_beat     (last_beat)
  );

`ifdef JTAG_AHB_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt;

  // Down-counter reloaded whenever the slave is not stalling a data phase;
  // reaching zero on the TIMEOUT_CYCLES-th stalled cycle fires the watchdog.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
    else if (state == ST_DATA && !HREADY)
      to_cnt <= to_cnt - 1'b1;
    else
      to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
  end

  assign timeout = (state == ST_DATA) && !HREADY && (to_cnt == '0);
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (cmd_valid) state_nxt = decode_nxt;
      ST_WAIT_WD: if (cmd_valid) state_nxt = cmd.is_addr ? decode_nxt : ST_ADDR;
      ST_ADDR:    if (write_q || !rb_full) state_nxt = ST_DATA;
      ST_DATA: begin
        if (timeout || (HREADY && HRESP))
          state_nxt = (write_q && !last_beat) ? ST_DRAIN : ST_IDLE;
        else if (HREADY)
          state_nxt = last_beat ? ST_IDLE : (write_q ? ST_WAIT_WD : ST_ADDR);
      end
      // beats_left was already stepped on the failing beat, so last_beat here
      // means this pop is the final orphaned DATA word.
      ST_DRAIN:   if (cmd_valid && (cmd.is_addr || last_beat)) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Output / control logic
  always_comb begin
    fifo_rinc  = 1'b0;
    htrans     = HTRANS_IDLE;
    rb_push    = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    wdata_load = 1'b0;
    err_set    = '0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          fifo_rinc = 1'b1;
          if (cmd_ok) load = 1'b1;
          else        err_set[ERR_PROTO] = 1'b1;
        end
      end
      ST_WAIT_WD: begin
        if (cmd_valid) begin
          fifo_rinc = 1'b1;
          if (!cmd.is_addr) begin
            wdata_load = 1'b1;
          end else begin
            // Burst cut short by a new command; restart decode on it.
            err_set[ERR_PROTO] = 1'b1;
            load = cmd_ok;
          end
        end
      end
      ST_ADDR: begin
        if (write_q || !rb_full) htrans = HTRANS_NONSEQ;
      end
      ST_DATA: begin
        if (timeout) begin
          err_set[ERR_TIMEOUT] = 1'b1;
          step = 1'b1;
        end else if (HREADY) begin
          step = 1'b1;
          if (HRESP)         err_set[ERR_HRESP] = 1'b1;
          else if (!write_q) rb_push = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cmd_valid && !cmd.is_addr) begin
          fifo_rinc = 1'b1;
          step = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      write_q <= 1'b0;
      wdata_q <= '0;
      err_q   <= '0;
    end else begin
      if (load)       write_q <= cmd.write;
      if (wdata_load) wdata_q <= cmd.addr;
      err_q <= (err_clr ? 3'b000 : err_q) | err_set;
    end
  end

  assign HADDR      = cur_addr;
  assign HTRANS     = htrans;
  assign HWRITE     = write_q;
  assign HSIZE      = {1'b0, cur_size};
  assign HWDATA     = wdata_q;
  assign rb_winc    = rb_push;
  assign rb_wdata   = rb_push ? HRDATA : '0;
  assign busy       = (state != ST_IDLE);
  assign err_status = err_q;

endmodule

// File: tb/tb_jtag_ahb_master_ctrl.sv
// Self-checking bench for jtag_ahb_master_ctrl: command FIFO, AHB slave and
// readback FIFO are modelled here; expected bus beats and data come from a
// word-list interpretation of the command stream.
module tb_jtag_ahb_master_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [40:0] fifo_rdata;
  logic        fifo_empty;
  logic        fifo_rinc;
  logic [31:0] rb_wdata;
  logic        rb_winc;
  logic        rb_full;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        err_clr;
  logic        busy;
  logic [2:0]  err_status;

  jtag_ahb_master_ctrl dut (
    .CLK(CLK), .RST(RST),
    .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_rinc(fifo_rinc),
    .rb_wdata(rb_wdata), .rb_winc(rb_winc), .rb_full(rb_full),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .err_clr(err_clr), .busy(busy), .err_status(err_status)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [40:0] cmd_q[$];
  logic [35:0] act_beats[$], exp_beats[$];
  logic [31:0] act_wd[$], exp_wd[$], act_rd[$], exp_rd[$];
  bit          exp_proto;

  logic        s_rinc = 0, s_rbw = 0, s_rbfull = 0, s_busy = 0, s_nonseq = 0, s_hwrite = 0;
  logic [31:0] s_rbdata = 0, s_haddr = 0, s_hwdata = 0;
  logic [2:0]  s_hsize = 0;

  bit          dp_active = 0, dp_err = 0, dp_write = 0, wait_rand = 0, rb_hold = 0;
  int          dp_wait = 0, dp_errph = 0, wait_fixed = 0, beat_no = 0, err_beat = -1, rb_cnt = 0;
  logic [31:0] dp_addr = 0;

  always @(negedge CLK) begin
    s_rinc   = fifo_rinc;
    s_rbw    = rb_winc;
    s_rbdata = rb_wdata;
    s_rbfull = rb_full;
    s_busy   = busy;
    s_nonseq = (HTRANS == 2'b10);
    s_haddr  = HADDR;
    s_hwrite = HWRITE;
    s_hsize  = HSIZE;
    s_hwdata = HWDATA;
  end

  function automatic logic [31:0] rdfunc(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F11;
  endfunction

  function automatic logic [40:0] mk_addr(input bit wr, input bit incr, input logic [1:0] size,
                                          input logic [3:0] m1, input logic [31:0] a);
    return {1'b1, m1, incr, wr, size, a};
  endfunction

  function automatic logic [40:0] mk_data(input logic [31:0] d);
    logic [7:0] junk;
    junk = 8'($urandom);
    return {1'b0, junk, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = (cmd_q.size() == 0);
    fifo_rdata = fifo_empty ? '0 : cmd_q[0];
  endtask

  // One bench cycle of the environment, run just after each rising edge using
  // the DUT outputs sampled on the preceding falling edge.
  task automatic model_step();
    if (RST) begin
      dp_active = 0; HREADY = 1'b1; HRESP = 1'b0; rb_cnt = 0;
      rb_full = rb_hold;
      refresh();
      return;
    end
    if (s_rinc) begin
      chk("pop_nonempty", cmd_q.size() > 0, 1);
      if (cmd_q.size() > 0) void'(cmd_q.pop_front());
    end
    if (s_rbw) begin
      act_rd.push_back(s_rbdata);
      chk("rb_push_while_full", s_rbfull, 0);
      rb_cnt++;
    end
    if (rb_cnt > 0 && $urandom_range(0, 1) == 1) rb_cnt--;
    rb_full = rb_hold || (rb_cnt >= 2);
    if (dp_active && HREADY) begin
      dp_active = 0;
      if (dp_write) act_wd.push_back(s_hwdata);
    end
    if (s_nonseq) begin
      act_beats.push_back({s_haddr, s_hwrite, s_hsize});
      dp_active = 1;
      dp_write  = s_hwrite;
      dp_addr   = s_haddr;
      dp_wait   = wait_rand ? int'($urandom_range(0, 2)) : wait_fixed;
      dp_err    = (beat_no == err_beat);
      dp_errph  = 0;
      beat_no++;
    end
    HRDATA = $urandom;
    if (dp_active) begin
      if (dp_wait > 0) begin
        HREADY = 1'b0; HRESP = 1'b0; dp_wait--;
      end else if (dp_err && dp_errph == 0) begin
        HREADY = 1'b0; HRESP = 1'b1; dp_errph = 1;
      end else if (dp_err) begin
        HREADY = 1'b1; HRESP = 1'b1;
      end else begin
        HREADY = 1'b1; HRESP = 1'b0;
        if (!dp_write) HRDATA = rdfunc(dp_addr);
      end
    end else begin
      HREADY = 1'b1; HRESP = 1'b0;
    end
    refresh();
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
      model_step();
    end
  endtask

  task automatic push_words(input logic [40:0] words[$]);
    foreach (words[i]) cmd_q.push_back(words[i]);
    refresh();
  endtask

  // Expected bus activity for a word stream on an error-free bus.
  task automatic model_cmds(input logic [40:0] cmds[$]);
    int          i, beats;
    logic [40:0] w;
    logic [31:0] a;
    logic [31:0] stp;
    i = 0;
    while (i < cmds.size()) begin
      w = cmds[i];
      i++;
      if (!w[40] || w[33:32] == 2'b11) begin
        exp_proto = 1;
        continue;
      end
      beats = int'(w[39:36]) + 1;
      a     = w[31:0];
      stp   = w[35] ? (32'd1 << w[33:32]) : 32'd0;
      for (int k = 0; k < beats; k++) begin
        if (w[34]) begin
          if (i >= cmds.size()) break;
          if (cmds[i][40]) begin
            exp_proto = 1;
            break;
          end
          exp_wd.push_back(cmds[i][31:0]);
          i++;
        end else begin
          exp_rd.push_back(rdfunc(a));
        end
        exp_beats.push_back({a, w[34], 1'b0, w[33:32]});
        a = a + stp;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    int quiet = 0;
    while (quiet < 3 && n < 3000) begin
      cyc(1);
      n++;
      if (cmd_q.size() == 0 && !s_busy && !dp_active) quiet++;
      else quiet = 0;
    end
    chk({tag, "_idle_in_time"}, n < 3000, 1);
  endtask

  task automatic compare(input string tag);
    chk({tag, "_nbeats"}, act_beats.size(), exp_beats.size());
    for (int i = 0; i < exp_beats.size() && i < act_beats.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), act_beats[i], exp_beats[i]);
    chk({tag, "_nwd"}, act_wd.size(), exp_wd.size());
    for (int i = 0; i < exp_wd.size() && i < act_wd.size(); i++)
      chk($sformatf("%s_wd%0d", tag, i), act_wd[i], exp_wd[i]);
    chk({tag, "_nrd"}, act_rd.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < act_rd.size(); i++)
      chk($sformatf("%s_rd%0d", tag, i), act_rd[i], exp_rd[i]);
    act_beats.delete(); exp_beats.delete();
    act_wd.delete();    exp_wd.delete();
    act_rd.delete();    exp_rd.delete();
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("err_cleared", err_status, 3'b000);
    exp_proto = 0;
  endtask

  initial begin
    logic [40:0] words[$];
    int          r, m1, nd;
    bit          wr;

    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0; rb_full = 1'b0; err_clr = 1'b0;
    fifo_empty = 1'b1; fifo_rdata = '0;

    // Reset values
    cyc(3);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_rinc", fifo_rinc, 0);
    chk("rst_rb_winc", rb_winc, 0);
    chk("rst_rb_wdata", rb_wdata, 0);
    chk("rst_htrans", HTRANS, 0);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hwrite", HWRITE, 0);
    chk("rst_hsize", HSIZE, 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_err", err_status, 0);
    RST = 1'b0;
    cyc(2);

    // Single write
    words = '{mk_addr(1, 0, 2'd2, 4'd0, 32'h0000_1000), mk_data(32'hDEAD_BEEF)};
    model_cmds(words);
    push_words(words);
    wait_idle("single_wr");
    chk("single_wr_busy", busy, 0);
    compare("single_wr");

    // 4-beat incrementing read, one wait state per beat
    wait_fixed = 1;
    words = '{mk_addr(0, 1, 2'd2, 4'd3, 32'h0000_2000)};
    model_cmds(words);
    push_words(words);
    wait_idle("incr_rd");
    compare("incr_rd");
    wait_fixed = 0;

    // Byte read wrapping past the top of the address space
    words = '{mk_addr(0, 1, 2'd0, 4'd1, 32'hFFFF_FFFF)};
    model_cmds(words);
    push_words(words);
    wait_idle("wrap");
    if (act_beats.size() >= 2) chk("wrap_haddr2", act_beats[1][35:4], 32'h0000_0000);
    compare("wrap");
    chk("no_err_yet", err_status, 3'b000);

    // Bus error on beat 2 of a 4-beat write, followed by a single read
    err_beat = beat_no + 1;
    words = '{mk_addr(1, 1, 2'd2, 4'd3, 32'h0000_3000),
              mk_data(32'h1111_0001), mk_data(32'h1111_0002),
              mk_data(32'h1111_0003), mk_data(32'h1111_0004),
              mk_addr(0, 0, 2'd2, 4'd0, 32'h0000_4000)};
    exp_beats = '{{32'h0000_3000, 1'b1, 3'd2}, {32'h0000_3004, 1'b1, 3'd2},
                  {32'h0000_4000, 1'b0, 3'd2}};
    exp_wd = '{32'h1111_0001, 32'h1111_0002};
    exp_rd = '{rdfunc(32'h0000_4000)};
    push_words(words);
    wait_idle("hresp");
    chk("hresp_err", err_status, 3'b001);
    chk("hresp_fifo_drained", cmd_q.size(), 0);
    compare("hresp");
    err_beat = -1;
    clear_err();

    // Readback FIFO full holds off the read
    rb_hold = 1;
    cyc(2);
    words = '{mk_addr(0, 1, 2'd1, 4'd1, 32'h0000_5002)};
    model_cmds(words);
    push_words(words);
    cyc(12);
    chk("rbfull_no_nonseq", act_beats.size(), 0);
    chk("rbfull_busy", s_busy, 1);
    rb_hold = 0;
    wait_idle("rbfull");
    compare("rbfull");

    // Protocol errors
    words = '{mk_data(32'hABCD_0000)};
    push_words(words);
    wait_idle("stray_data");
    chk("stray_data_err", err_status, 3'b010);
    clear_err();
    words = '{mk_addr(0, 0, 2'd3, 4'd0, 32'h0000_6000)};
    push_words(words);
    wait_idle("size3");
    chk("size3_err", err_status, 3'b010);
    chk("size3_no_beat", act_beats.size(), 0);
    clear_err();
    // set wins over clear in the same cycle
    err_clr = 1'b1;
    words = '{mk_data(32'h0BAD_0BAD)};
    push_words(words);
    cyc(1);
    err_clr = 1'b0;
    chk("set_dominant", err_status, 3'b010);
    wait_idle("set_dom");
    clear_err();

    // Randomized command stream with random wait states
    wait_rand = 1;
    words.delete();
    for (int c = 0; c < 40; c++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        words.push_back(mk_data($urandom));
      end else if (r == 1) begin
        words.push_back(mk_addr($urandom_range(0, 1), 0, 2'd3, 4'd0, $urandom));
      end else begin
        wr = ($urandom_range(0, 1) == 1);
        m1 = $urandom_range(0, 3);
        words.push_back(mk_addr(wr, $urandom_range(0, 1), 2'($urandom_range(0, 2)),
                                4'(m1), $urandom));
        if (wr) begin
          nd = (r == 2) ? int'($urandom_range(0, m1)) : m1 + 1;
          for (int d = 0; d < nd; d++) words.push_back(mk_data($urandom));
        end
      end
    end
    words.push_back(mk_addr(0, 0, 2'd2, 4'd0, 32'h0000_7000));
    model_cmds(words);
    push_words(words);
    wait_idle("random");
    chk("random_err", err_status, {1'b0, exp_proto, 1'b0});
    compare("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
